// File: rtl/riscv_alu_pkg.sv
// Shared ALU select codes, opcodes and funct7 constants for the decode stage and the ALU.
package riscv_alu_pkg;

  localparam logic [4:0] ALU_SEL_ADDI  = 5'd0;
  localparam logic [4:0] ALU_SEL_SLTI  = 5'd1;
  localparam logic [4:0] ALU_SEL_SLTIU = 5'd2;
  localparam logic [4:0] ALU_SEL_XORI  = 5'd3;
  localparam logic [4:0] ALU_SEL_ORI   = 5'd4;
  localparam logic [4:0] ALU_SEL_ANDI  = 5'd5;
  localparam logic [4:0] ALU_SEL_SLLI  = 5'd6;
  localparam logic [4:0] ALU_SEL_SRLI  = 5'd7;
  localparam logic [4:0] ALU_SEL_SRAI  = 5'd8;
  localparam logic [4:0] ALU_SEL_ADD   = 5'd9;
  localparam logic [4:0] ALU_SEL_SUB   = 5'd10;
  localparam logic [4:0] ALU_SEL_SLL   = 5'd11;
  localparam logic [4:0] ALU_SEL_SLT   = 5'd12;
  localparam logic [4:0] ALU_SEL_SLTU  = 5'd13;
  localparam logic [4:0] ALU_SEL_XOR   = 5'd14;
  localparam logic [4:0] ALU_SEL_SRL   = 5'd15;
  localparam logic [4:0] ALU_SEL_SRA   = 5'd16;
  localparam logic [4:0] ALU_SEL_OR    = 5'd17;
  localparam logic [4:0] ALU_SEL_AND   = 5'd18;
  localparam logic [4:0] ALU_SEL_LUI   = 5'd19;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational decode of an RV32I OP-IMM / OP / LUI word into ALU select, immediate and operand controls.
module rv_alu_decode
  import riscv_alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_alu_sel,
  output logic [31:0] o_imm,
  output logic        o_use_imm,
  output logic        o_zero_in1,
  output logic        o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_rd;

  assign w_opcode    = i_instr[6:0];
  assign w_funct3    = i_instr[14:12];
  assign w_funct7    = i_instr[31:25];
  assign w_unused_rd = &{1'b0, i_instr[11:7]};

  always_comb begin
    o_alu_sel  = ALU_SEL_ADDI;
    o_imm      = '0;
    o_use_imm  = 1'b0;
    o_zero_in1 = 1'b0;
    o_illegal  = 1'b0;
    case (w_opcode)
      OPC_OP_IMM: begin
        o_use_imm = 1'b1;
        o_imm     = {{20{i_instr[31]}}, i_instr[31:20]};
        case (w_funct3)
          3'b000: o_alu_sel = ALU_SEL_ADDI;
          3'b010: o_alu_sel = ALU_SEL_SLTI;
          3'b011: o_alu_sel = ALU_SEL_SLTIU;
          3'b100: o_alu_sel = ALU_SEL_XORI;
          3'b110: o_alu_sel = ALU_SEL_ORI;
          3'b111: o_alu_sel = ALU_SEL_ANDI;
          // Shifts carry a 5-bit shamt; the upper immediate bits are a funct7 qualifier.
          3'b001: begin
            o_imm = {27'b0, i_instr[24:20]};
            if (w_funct7 == F7_BASE) o_alu_sel = ALU_SEL_SLLI;
            else                     o_illegal = 1'b1;
          end
          3'b101: begin
            o_imm = {27'b0, i_instr[24:20]};
            if (w_funct7 == F7_BASE)     o_alu_sel = ALU_SEL_SRLI;
            else if (w_funct7 == F7_ALT) o_alu_sel = ALU_SEL_SRAI;
            else                         o_illegal = 1'b1;
          end
          default: o_illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            3'b000:  o_alu_sel = ALU_SEL_ADD;
            3'b001:  o_alu_sel = ALU_SEL_SLL;
            3'b010:  o_alu_sel = ALU_SEL_SLT;
            3'b011:  o_alu_sel = ALU_SEL_SLTU;
            3'b100:  o_alu_sel = ALU_SEL_XOR;
            3'b101:  o_alu_sel = ALU_SEL_SRL;
            3'b110:  o_alu_sel = ALU_SEL_OR;
            default: o_alu_sel = ALU_SEL_AND;
          endcase
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          o_alu_sel = ALU_SEL_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
          o_alu_sel = ALU_SEL_SRA;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        o_alu_sel  = ALU_SEL_LUI;
        o_use_imm  = 1'b1;
        o_zero_in1 = 1'b1;
        o_imm      = {i_instr[31:12], 12'b0};
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) o_alu_sel = ALU_SEL_ADDI;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: operand read, ALU decode and a single-entry valid/ready pipeline register.
// Optional macro ID_EX_FORWARD_EN enables writeback forwarding onto rs1/rs2 at load time.
module id_ex_stage
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [4:0]      alu_sel,
  output logic [4:0]      rd,
  output logic            rd_wen,
  output logic            illegal
);

  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // the held entry stays stable while out_valid is high and out_ready is low.
  logic [4:0]      w_alu_sel;
  logic [31:0]     w_imm;
  logic            w_use_imm;
  logic            w_zero_in1;
  logic            w_illegal;
  logic            w_load;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_in1;
  logic [XLEN-1:0] w_in2;
  logic [4:0]      w_rd;
  logic            w_rd_wen;

  rv_alu_decode u_decode (
    .i_instr    (in_instr),
    .o_alu_sel  (w_alu_sel),
    .o_imm      (w_imm),
    .o_use_imm  (w_use_imm),
    .o_zero_in1 (w_zero_in1),
    .o_illegal  (w_illegal)
  );

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign in_ready = !flush && (!out_valid || out_ready);
  assign w_load   = in_valid && in_ready;

`ifdef ID_EX_FORWARD_EN
  assign w_rs1_val = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rs1_addr) ? fwd_data : rs1_data;
  assign w_rs2_val = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rs2_addr) ? fwd_data : rs2_data;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = &{1'b0, fwd_valid, fwd_rd, fwd_data};
  assign w_rs1_val    = rs1_data;
  assign w_rs2_val    = rs2_data;
`endif

  assign w_in1    = (w_illegal || w_zero_in1) ? '0 : w_rs1_val;
  assign w_in2    = w_illegal ? '0 : (w_use_imm ? w_imm : w_rs2_val);
  assign w_rd     = in_instr[11:7];
  assign w_rd_wen = !w_illegal && (w_rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_sel   <= '0;
      rd        <= '0;
      rd_wen    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (w_load)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (w_load) begin
        alu_in1 <= w_in1;
        alu_in2 <= w_in2;
        alu_sel <= w_alu_sel;
        rd      <= w_rd;
        rd_wen  <= w_rd_wen;
        illegal <= w_illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, decode sweep, illegal encodings, backpressure/flush, x0, forwarding.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [4:0]  alu_sel;
  logic [4:0]  rd;
  logic        rd_wen;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] R1 = 32'h1111_2222;
  localparam logic [31:0] R2 = 32'h0000_0ABC;
`ifdef ID_EX_FORWARD_EN
  localparam logic [31:0] FWD_EXP = 32'd7;
`else
  localparam logic [31:0] FWD_EXP = 32'd1;
`endif

  logic [31:0] sw_instr [20];
  logic [4:0]  sw_sel   [20];
  logic [31:0] sw_in1   [20];
  logic [31:0] sw_in2   [20];

  id_ex_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_sel   (alu_sel),
    .rd        (rd),
    .rd_wen    (rd_wen),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rdx);
    return {imm, rs1, f3, rdx, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rdx);
    return {f7, rs2, rs1, f3, rdx, 7'b0110011};
  endfunction

  task automatic chk_illegal(input string tag, input logic [4:0] exp_rd);
    chk({tag, "_valid"},   {31'b0, out_valid}, 32'd1);
    chk({tag, "_illegal"}, {31'b0, illegal},   32'd1);
    chk({tag, "_rd_wen"},  {31'b0, rd_wen},    32'd0);
    chk({tag, "_sel"},     {27'b0, alu_sel},   32'd0);
    chk({tag, "_in1"},     alu_in1,            32'd0);
    chk({tag, "_in2"},     alu_in2,            32'd0);
    chk({tag, "_rd"},      {27'b0, rd},        {27'b0, exp_rd});
  endtask

  initial begin
    // Decode sweep table: rd field left 0 here and filled per entry at drive time.
    sw_instr[0]  = enc_i(12'h123, 5'd1, 3'b000, 5'd0); sw_sel[0]  = 5'd0;  sw_in2[0]  = 32'h0000_0123;
    sw_instr[1]  = enc_i(12'h800, 5'd1, 3'b010, 5'd0); sw_sel[1]  = 5'd1;  sw_in2[1]  = 32'hFFFF_F800;
    sw_instr[2]  = enc_i(12'h7FF, 5'd1, 3'b011, 5'd0); sw_sel[2]  = 5'd2;  sw_in2[2]  = 32'h0000_07FF;
    sw_instr[3]  = enc_i(12'h0F0, 5'd1, 3'b100, 5'd0); sw_sel[3]  = 5'd3;  sw_in2[3]  = 32'h0000_00F0;
    sw_instr[4]  = enc_i(12'h00F, 5'd1, 3'b110, 5'd0); sw_sel[4]  = 5'd4;  sw_in2[4]  = 32'h0000_000F;
    sw_instr[5]  = enc_i(12'hFFF, 5'd1, 3'b111, 5'd0); sw_sel[5]  = 5'd5;  sw_in2[5]  = 32'hFFFF_FFFF;
    sw_instr[6]  = enc_i(12'h01F, 5'd1, 3'b001, 5'd0); sw_sel[6]  = 5'd6;  sw_in2[6]  = 32'd31;
    sw_instr[7]  = enc_i(12'h003, 5'd1, 3'b101, 5'd0); sw_sel[7]  = 5'd7;  sw_in2[7]  = 32'd3;
    sw_instr[8]  = enc_i(12'h407, 5'd1, 3'b101, 5'd0); sw_sel[8]  = 5'd8;  sw_in2[8]  = 32'd7;
    sw_instr[9]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0); sw_sel[9]  = 5'd9;  sw_in2[9]  = R2;
    sw_instr[10] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd0); sw_sel[10] = 5'd10; sw_in2[10] = R2;
    sw_instr[11] = enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd0); sw_sel[11] = 5'd11; sw_in2[11] = R2;
    sw_instr[12] = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd0); sw_sel[12] = 5'd12; sw_in2[12] = R2;
    sw_instr[13] = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd0); sw_sel[13] = 5'd13; sw_in2[13] = R2;
    sw_instr[14] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd0); sw_sel[14] = 5'd14; sw_in2[14] = R2;
    sw_instr[15] = enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd0); sw_sel[15] = 5'd15; sw_in2[15] = R2;
    sw_instr[16] = enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd0); sw_sel[16] = 5'd16; sw_in2[16] = R2;
    sw_instr[17] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd0); sw_sel[17] = 5'd17; sw_in2[17] = R2;
    sw_instr[18] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd0); sw_sel[18] = 5'd18; sw_in2[18] = R2;
    sw_instr[19] = {20'h12345, 5'd0, 7'b0110111};          sw_sel[19] = 5'd19; sw_in2[19] = 32'h1234_5000;
    for (int i = 0; i < 20; i++) sw_in1[i] = (i == 19) ? 32'd0 : R1;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    rs1_data = '0; rs2_data = '0; fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
    out_ready = 1'b0;

    // Reset values, also with an instruction presented under reset.
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = enc_i(12'hFFF, 5'd1, 3'b000, 5'd5); rs1_data = 32'd10;
    tick();
    chk("rst_valid2", {31'b0, out_valid}, 32'd0);
    chk("rst_in1",    alu_in1,            32'd0);
    chk("rst_in2",    alu_in2,            32'd0);
    chk("rst_sel",    {27'b0, alu_sel},   32'd0);
    chk("rst_rd",     {27'b0, rd},        32'd0);
    chk("rst_rd_wen", {31'b0, rd_wen},    32'd0);
    chk("rst_illegal",{31'b0, illegal},   32'd0);
    chk("rs1_addr",   {27'b0, rs1_addr},  32'd1);
    chk("rs2_addr",   {27'b0, rs2_addr},  32'd31);

    // ADDI x5, x1, -1 with rs1 = 10.
    rst_n = 1'b1;
    #1;
    chk("addi_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("addi_valid",  {31'b0, out_valid}, 32'd1);
    chk("addi_sel",    {27'b0, alu_sel},   32'd0);
    chk("addi_in1",    alu_in1,            32'd10);
    chk("addi_in2",    alu_in2,            32'hFFFF_FFFF);
    chk("addi_rd",     {27'b0, rd},        32'd5);
    chk("addi_rd_wen", {31'b0, rd_wen},    32'd1);
    chk("addi_illegal",{31'b0, illegal},   32'd0);

    // Back-to-back decode sweep with out_ready held high: one result per cycle.
    rs1_data = R1; rs2_data = R2;
    for (int i = 0; i < 20; i++) begin
      logic [4:0] k;
      k = 5'(i + 1);
      in_instr = sw_instr[i] | {20'b0, k, 7'b0};
      #1;
      chk($sformatf("sw%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      tick();
      chk($sformatf("sw%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("sw%0d_sel", i),   {27'b0, alu_sel},   {27'b0, sw_sel[i]});
      chk($sformatf("sw%0d_in1", i),   alu_in1,            sw_in1[i]);
      chk($sformatf("sw%0d_in2", i),   alu_in2,            sw_in2[i]);
      chk($sformatf("sw%0d_rd", i),    {27'b0, rd},        {27'b0, k});
      chk($sformatf("sw%0d_wen", i),   {31'b0, rd_wen},    32'd1);
      chk($sformatf("sw%0d_ill", i),   {31'b0, illegal},   32'd0);
    end

    // Illegal encodings still flow through the handshake with zeroed payload.
    in_instr = {7'b0, 5'd2, 5'd1, 3'b000, 5'd4, 7'b1100011};
    tick(); chk_illegal("ill_branch", 5'd4);
    in_instr = enc_r(7'h20, 5'd2, 5'd1, 3'b001, 5'd4);
    tick(); chk_illegal("ill_op_alt_sll", 5'd4);
    in_instr = enc_i(12'h405, 5'd1, 3'b001, 5'd4);
    tick(); chk_illegal("ill_slli_f7", 5'd4);
    in_instr = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd4);
    tick(); chk_illegal("ill_op_f7_01", 5'd4);

    // ADD x0 is legal but must not write.
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0);
    tick();
    chk("x0_sel",     {27'b0, alu_sel}, 32'd9);
    chk("x0_rd_wen",  {31'b0, rd_wen},  32'd0);
    chk("x0_illegal", {31'b0, illegal}, 32'd0);

    // Backpressure: hold ADDI x6, x1, 5 while a XORI waits upstream.
    rs1_data = 32'd10;
    in_instr = enc_i(12'h005, 5'd1, 3'b000, 5'd6);
    tick();
    chk("bp_load_in2", alu_in2, 32'd5);
    in_instr = enc_i(12'h0F0, 5'd1, 3'b100, 5'd9);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
      tick();
      chk($sformatf("bp%0d_valid", c), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_sel", c),   {27'b0, alu_sel},   32'd0);
      chk($sformatf("bp%0d_in2", c),   alu_in2,            32'd5);
      chk($sformatf("bp%0d_rd", c),    {27'b0, rd},        32'd6);
    end
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("post_flush_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("post_flush_valid", {31'b0, out_valid}, 32'd0);

    // Drain without a new load clears out_valid.
    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = enc_i(12'h0F0, 5'd1, 3'b100, 5'd9);
    tick();
    chk("xori_sel", {27'b0, alu_sel}, 32'd3);
    chk("xori_rd",  {27'b0, rd},      32'd9);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // Forwarding: ADD x3, x2, x2 with writeback to x2 in flight.
    in_valid = 1'b1; rs1_data = 32'd1; rs2_data = 32'd1;
    fwd_valid = 1'b1; fwd_rd = 5'd2; fwd_data = 32'd7;
    in_instr = enc_r(7'h00, 5'd2, 5'd2, 3'b000, 5'd3);
    tick();
    chk("fwd_in1", alu_in1, FWD_EXP);
    chk("fwd_in2", alu_in2, FWD_EXP);
    fwd_rd = 5'd0;
    tick();
    chk("fwd_x0_in1", alu_in1, 32'd1);
    chk("fwd_x0_in2", alu_in2, 32'd1);
    fwd_rd = 5'd2; fwd_valid = 1'b0;
    tick();
    chk("fwd_inv_in1", alu_in1, 32'd1);
    chk("fwd_inv_in2", alu_in2, 32'd1);
    fwd_valid = 1'b1;
    in_instr = enc_r(7'h00, 5'd5, 5'd2, 3'b000, 5'd3);
    tick();
    chk("fwd_rs1_only_in1", alu_in1, FWD_EXP);
    chk("fwd_rs1_only_in2", alu_in2, 32'd1);

    // Asynchronous reset mid-operation clears the held entry without a clock edge.
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid",  {31'b0, out_valid}, 32'd0);
    chk("async_rst_in1",    alu_in1,            32'd0);
    chk("async_rst_rd",     {27'b0, rd},        32'd0);
    chk("async_rst_rd_wen", {31'b0, rd_wen},    32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage directly upstream of the integer ALU. Accepts one RV32I instruction per cycle via valid/ready, reads register-file operands, decodes OP-IMM/OP/LUI into the 5-bit ALU select code, and registers the select code, operands and destination into a single-entry pipeline register. The ALU consumes the registered outputs combinationally.

## Interface
- `XLEN`, 32, datapath width. Only 32 is supported.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: squashes the held entry and blocks acceptance this cycle.
- `in_valid` in 1: instruction valid.
- `in_ready` out 1: stage can accept.
- `in_instr` in 32: instruction word.
- `rs1_addr`, `rs2_addr` out 5 each: `in_instr[19:15]` and `in_instr[24:20]`, combinational.
- `rs1_data`, `rs2_data` in 32 each: register-file read data, valid in the same cycle.
- `fwd_valid` in 1, `fwd_rd` in 5, `fwd_data` in 32: writeback forwarding source.
- `out_valid` out 1: ALU inputs valid.
- `out_ready` in 1: downstream accepts.
- `alu_in1`, `alu_in2` out 32 each: ALU operands.
- `alu_sel` out 5: ALU select code.
- `rd` out 5: destination register.
- `rd_wen` out 1: register write enable.
- `illegal` out 1: held instruction is not decodable.

## Operation
- **ALU select codes.**
  - OP-IMM (opcode 0010011): ADDI 0, SLTI 1, SLTIU 2, XORI 3, ORI 4, ANDI 5, SLLI 6, SRLI 7, SRAI 8.
  - OP (opcode 0110011): ADD 9, SUB 10, SLL 11, SLT 12, SLTU 13, XOR 14, SRL 15, SRA 16, OR 17, AND 18.
  - LUI (opcode 0110111): 19.
- **OP-IMM decode.**
  - Select by funct3.
  - `alu_in2` is the sign-extended `instr[31:20]`.
  - For shifts, `alu_in2` is instead the zero-extended `instr[24:20]`.
  - SLLI and SRLI require funct7 = 0000000. SRAI requires funct7 = 0100000.
- **OP decode.**
  - funct7 = 0000000 selects by funct3.
  - funct7 = 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - `alu_in2` = rs2 value.
- **LUI decode.** `alu_in1` = 0, `alu_in2` = `{instr[31:12], 12'b0}`.
- **Operand 1.** For OP-IMM and OP, `alu_in1` = rs1 value.
- **Illegal instructions.** Any other opcode/funct combination sets `illegal` = 1, `alu_sel` = 0, `rd_wen` = 0, operands = 0. The entry still flows through the handshake.
- **Write enable.** `rd` = `instr[11:7]`. `rd_wen` = legal AND `rd` != 0.
- **Handshake.**
  - `in_ready` = !flush AND (!out_valid OR out_ready).
  - Load occurs when `in_valid` AND `in_ready`.
  - Outputs hold stable while `out_valid` AND !`out_ready`.
- **out_valid next state.**
  - flush → 0.
  - Otherwise, load → 1.
  - Otherwise, `out_ready` → 0.
  - Otherwise hold.
- **Simultaneous events.**
  - Accept and drain in the same cycle: the new entry replaces the old one with no bubble.
  - Flush with `in_valid`: the input is not accepted.

## Timing
- Latency is one cycle from an accepted input to `out_valid`. Sustained throughput is 1 instruction per cycle.
- All outputs are registered except `in_ready`, `rs1_addr` and `rs2_addr`.
- On reset, every registered output is 0: `out_valid`, `alu_in1`, `alu_in2`, `alu_sel`, `rd`, `rd_wen`, `illegal`.
- Reset mid-operation discards the held entry immediately (asynchronous).
- Forwarding compares against `fwd_*` in the same cycle as the load.

## Configuration
- Macro: `ID_EX_FORWARD_EN`.
- **Defined:** on load, if `fwd_valid` AND `fwd_rd` != 0 AND `fwd_rd` == `rs1_addr`, then rs1 value = `fwd_data`; otherwise rs1 value = `rs1_data`. The same rule applies independently to rs2.
- **Undefined:** the rs values are always `rs1_data` / `rs2_data`. The `fwd_*` ports remain present and are ignored.

## Structure
- Package `riscv_alu_pkg` holds:
  - the `ALU_SEL_*` localparams 0–19, shared with the ALU;
  - the `OPC_OP_IMM`, `OPC_OP` and `OPC_LUI` opcodes;
  - the funct7 constants `F7_BASE` and `F7_ALT`.
- Sub-module `rv_alu_decode`: purely combinational decode of `instr` into `alu_sel`, immediate, `use_imm`, `zero_in1` and `illegal`.
- `id_ex_stage` wraps `rv_alu_decode` with forwarding muxes and the pipeline register.

## Test plan
- **Reset and single ADDI.** Drive `rst_n` low. Then load ADDI x5, x1, -1 with `rs1_data` = 10. Expect: during reset, all outputs 0. Next cycle: `alu_sel` 0, `alu_in1` 10, `alu_in2` 0xFFFFFFFF, `rd` 5, `rd_wen` 1.
- **Full decode sweep.** Cover every legal funct3/funct7 encoding plus LUI 0x12345. Expect codes 0–19 exactly. For LUI: `alu_in2` 0x12345000, `alu_in1` 0.
- **Illegal instructions.** Load opcode 1100011, and separately OP with funct7 0100000 and funct3 001. Expect `illegal` 1, `rd_wen` 0, `alu_sel` 0.
- **Backpressure and flush.** Hold `out_ready` 0 for 3 cycles with `in_valid` 1. Expect outputs stable and `in_ready` 0. Then assert flush: `out_valid` 0 next cycle and no input accepted that cycle.
- **Back-to-back and x0.** Run back-to-back loads with `out_ready` = 1. Expect one output per cycle and no bubbles. ADD x0: expect `rd_wen` 0.
- **Forwarding.** With `ID_EX_FORWARD_EN` defined, load ADD x3, x2, x2 with `fwd_rd` 2, `fwd_data` 7, `rs*_data` 1. Expect both operands 7. With `fwd_rd` 0, expect both operands 1. With the macro undefined, expect 1.
